// File: rtl/rtc_addr_pkg.sv
// Shared encodings and the default RTC register address table for the address sequencer.
package rtc_addr_pkg;

  localparam logic [1:0] MODE_SINGLE    = 2'd0;
  localparam logic [1:0] MODE_BURST     = 2'd1;
  localparam logic [1:0] MODE_CMD_BURST = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  // Index 0 is the control register, 1..6 the date/time block, 7..9 the timer block.
  function automatic logic [7:0] rtc_table_entry(input int idx);
    case (idx)
      0:       return 8'hF0;
      1:       return 8'h21;
      2:       return 8'h22;
      3:       return 8'h23;
      4:       return 8'h24;
      5:       return 8'h25;
      6:       return 8'h26;
      7:       return 8'h41;
      8:       return 8'h42;
      9:       return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_addr_rom.sv
// Combinational index-to-address lookup; indices at or beyond N_ENTRIES read as zero.
module rtc_addr_rom
  import rtc_addr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4,
  parameter int N_ENTRIES = 10
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] entry [N_ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      assign entry[gi] = DATA_W'(rtc_table_entry(gi));
    end
  endgenerate

  always_comb begin
    data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (idx == IDX_W'(i)) data = entry[i];
    end
  end

endmodule

// File: rtl/rtc_addr_sequencer.sv
// Turns one start request into an ordered valid/ready stream of RTC register addresses.
module rtc_addr_sequencer
  import rtc_addr_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                N_ENTRIES = 10,
  parameter int                IDX_W     = 4,
  parameter logic [DATA_W-1:0] CMD_ADDR  = DATA_W'(8'hF0)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              abort,
  input  logic              addr_ready,
  output logic [DATA_W-1:0] addr_out,
  output logic              addr_valid,
  output logic [IDX_W-1:0]  seq_index,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_ENTRIES);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0] addr_out_q, addr_out_d;
  logic [IDX_W-1:0]  seq_index_q, seq_index_d;
  logic              addr_valid_q, addr_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] rom_data;
  logic              first_oor, last_oor, req_bad, hs, emitting;

  assign first_oor = {1'b0, first_idx} >= N_LIM;
  assign last_oor  = {1'b0, last_idx} >= N_LIM;
  assign req_bad   = !(mode inside {MODE_SINGLE, MODE_BURST, MODE_CMD_BURST}) || first_oor ||
                     ((mode != MODE_SINGLE) && (last_oor || (first_idx > last_idx)));
  assign hs        = addr_valid_q && addr_ready;

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    last_d    = last_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            cur_idx_d = first_idx;
            last_d    = (mode == MODE_SINGLE) ? first_idx : last_idx;
            state_d   = (mode == MODE_CMD_BURST) ? S_CMD : S_RUN;
          end
        end
      end
      S_CMD: begin
        if (abort)   state_d = S_IDLE;
        else if (hs) state_d = S_RUN;
      end
      S_RUN: begin
        // abort wins over a same-cycle handshake: the sequence simply stops
        if (abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          if (cur_idx_q == last_q) state_d = S_DONE;
          else                     cur_idx_d = cur_idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the table is looked up on the next index.
  rtc_addr_rom #(
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .N_ENTRIES (N_ENTRIES)
  ) u_rom (
    .idx  (cur_idx_d),
    .data (rom_data)
  );

  assign emitting     = (state_d == S_CMD) || (state_d == S_RUN);
  assign addr_out_d   = (state_d == S_CMD) ? CMD_ADDR : ((state_d == S_RUN) ? rom_data : '0);
  assign seq_index_d  = (state_d == S_RUN) ? cur_idx_d : '0;
  assign addr_valid_d = emitting;
  assign busy_d       = emitting;
  assign done_d       = (state_d == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_idx_q    <= '0;
      last_q       <= '0;
      addr_out_q   <= '0;
      seq_index_q  <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      last_q       <= last_d;
      addr_out_q   <= addr_out_d;
      seq_index_q  <= seq_index_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign addr_out   = addr_out_q;
  assign addr_valid = addr_valid_q;
  assign seq_index  = seq_index_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/rtc_addr_sequencer.md
Name: rtc_addr_sequencer

Overview:
Parametrised address sequencer for the RTC register interface. It turns a single start request into an ordered stream of RTC register addresses. Each address is handed to the bus transaction engine over a valid/ready handshake. Supported modes are single-register access, a burst over an index range, and a command-prefixed burst, so the control FSM can sweep the date/time block or the timer block with one request.

Parameters:
- DATA_W, 8, width of an emitted register address.
- N_ENTRIES, 10, number of valid entries in the address table (indices 0..N_ENTRIES-1).
- IDX_W, 4, width of the index inputs and seq_index; must satisfy 2**IDX_W >= N_ENTRIES.
- CMD_ADDR, 8'hF0, command/control address emitted first in mode CMD_BURST.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  0=SINGLE, 1=BURST, 2=CMD_BURST, 3=reserved (treated as invalid).
- first_idx  in  IDX_W  first table index (the only index in SINGLE).
- last_idx  in  IDX_W  last table index, inclusive; ignored in SINGLE.
- abort  in  1  cancels any sequence in progress.
- addr_ready  in  1  downstream ready.
- addr_out  out  DATA_W  current address.
- addr_valid  out  1  addr_out is valid.
- seq_index  out  IDX_W  table index of addr_out; 0 while emitting CMD_ADDR.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Address table, index to address:
  - 0 -> 8'hF0, 1..6 -> 8'h21..8'h26 (date/time registers).
  - 7 -> 8'h41, 8 -> 8'h42, 9 -> 8'h43 (timer seconds, minutes, hours).
  - Entries are zero-extended or truncated to DATA_W.
- Reset (reset_n=0, asynchronous): state=IDLE. addr_out=0, addr_valid=0, seq_index=0, busy=0, done=0, err=0. All inputs are latched as 0.
- FSM states: IDLE, CMD, RUN, DONE.
- Request validation in IDLE, when start=1:
  - The request is invalid if mode=3, or first_idx>=N_ENTRIES, or (mode!=SINGLE and (last_idx>=N_ENTRIES or first_idx>last_idx)).
  - Invalid request: err=1 for exactly the next cycle; state stays IDLE; no address is emitted.
  - Valid request: mode, first_idx and last_idx (last_idx=first_idx for SINGLE) are latched.
    - Next state is CMD for CMD_BURST, otherwise RUN.
    - busy=1 and addr_valid=1 from the next cycle on. Latency from start to first valid address is 1 cycle.
- CMD state: addr_out=CMD_ADDR, seq_index=0. When addr_valid and addr_ready are both high, go to RUN at the latched first_idx.
- RUN state: addr_out=table[cur_idx], seq_index=cur_idx. On each handshake:
  - If cur_idx=last, go to DONE.
  - Otherwise cur_idx increments and the next address is valid the following cycle. Back-to-back throughput is one address per cycle when ready is held high.
- Handshake hold rule: while addr_valid=1 and addr_ready=0, addr_out and seq_index hold stable and addr_valid stays 1.
- DONE state (one cycle): done=1, busy=0, addr_valid=0; then IDLE. Because of this cycle, a new start is accepted no earlier than 2 cycles after the final handshake.
- Abort:
  - In CMD or RUN, abort=1 moves the FSM to IDLE on the next edge, with busy=0 and addr_valid=0.
  - done is not pulsed after an abort.
  - Abort has priority over a same-cycle handshake. That handshake still counts downstream, but the sequencer does not advance.
  - abort is ignored in IDLE and DONE.
- start while busy or in DONE: ignored, with no err.
- Index counter never wraps: validation guarantees last<N_ENTRIES.
- Mid-operation reset: outputs return to reset values immediately, with no done and no err.

Decomposition:
- Package rtc_addr_pkg holds:
  - mode encodings (MODE_SINGLE, MODE_BURST, MODE_CMD_BURST);
  - FSM state encodings;
  - the default address table constants.
- Sub-module rtc_addr_rom is combinational, parametrised by DATA_W, IDX_W and N_ENTRIES.
  - It maps index to address and returns 0 for out-of-range indices.
  - The sequencer instantiates it once, driven by cur_idx.

Test Plan:
1. Reset, then mode=SINGLE, first_idx=8, ready held high -> next cycle addr_out=8'h42 with valid=1; the cycle after, done=1 for one cycle; busy=0 afterwards.
2. mode=BURST, first=1, last=6, ready high -> addresses 21,22,23,24,25,26 on consecutive cycles with seq_index 1..6; done 1 cycle after 8'h26; total of 6 handshakes.
3. mode=CMD_BURST, first=7, last=9, ready toggling 1,0,0,1,... -> sequence F0,41,42,43; addr_out stays stable during each ready=0 cycle; done after 8'h43.
4. Invalid requests: first=3/last=2, first=10, and mode=3 -> each gives err=1 for one cycle, addr_valid stays 0, busy stays 0.
5. BURST first=1, last=6; abort asserted together with the handshake on 8'h23 -> next cycle valid=0, busy=0, state IDLE, no done; a new start is accepted the following cycle.
6. reset_n pulled low during RUN while addr_valid=1 and ready=0 -> all outputs go to 0 asynchronously; after release, no done or err and the FSM is in IDLE.
